ssd_entry_scanner: RTL and testbench
====================================

SSD_ENTRY_SCANNER -- requirements
Module: ssd_entry_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of buffered/displayed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 250_000, clk cycles each digit is displayed (legal >= 2).
REQ-003 SHALL have parameter SHIFT_MODE, default 0; 0 = circular slot overwrite, 1 = shift-left entry.
REQ-004 SHALL have parameter ENTER_KEY, default 4'hF, key code that terminates an entry.
REQ-005 SHALL have parameter BKSP_KEY, default 4'hE, key code that deletes the last digit.
REQ-006 SHALL have port clk  input  1  system clock; one clock domain.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port key_valid  input  1  single-cycle pulse, key_code valid.
REQ-009 SHALL have port key_code  input  4  decoded keypad value.
REQ-010 SHALL have port clear  input  1  synchronous buffer clear.
REQ-011 SHALL have port digits  output  4*NUM_DIGITS  digit buffer; digit i at [4i+3:4i].
REQ-012 SHALL have port digit_count  output  $clog2(NUM_DIGITS+1)  number of valid digits.
REQ-013 SHALL have port full  output  1  high when digit_count == NUM_DIGITS.
REQ-014 SHALL have port entry_done  output  1  one-cycle pulse when ENTER_KEY accepted.
REQ-015 SHALL have port scan_sel  output  $clog2(NUM_DIGITS)  index of digit currently driven.
REQ-016 SHALL have port scan_seg  output  7  active-high segments (a..g) for digit scan_sel.

Function
REQ-017 Entry FSM SHALL have states ENTRY and DONE; key_valid only acts on the cycle it is high.
REQ-018 In ENTRY, a key not equal to ENTER_KEY or BKSP_KEY SHALL be stored and, if not full, increment digit_count, all visible the next cycle.
REQ-019 SHIFT_MODE=0: key SHALL write slot wr_ptr, wr_ptr advances, wraps NUM_DIGITS-1 -> 0; when full, writes overwrite the oldest slot and count stays NUM_DIGITS.
REQ-020 SHIFT_MODE=1: digits SHALL shift up one position (digit[N-1] discarded), new key into digit 0.
REQ-021 BKSP_KEY with digit_count > 0 SHALL decrement count and zero the last-written digit (mode 0: slot wr_ptr-1 with wrap, pointer steps back; mode 1: shift down, zero into top); with count 0 it SHALL be ignored.
REQ-022 ENTER_KEY in ENTRY SHALL pulse entry_done the next cycle, move to DONE and hold digits unchanged.
REQ-023 In DONE, any key_valid SHALL clear buffer, count and pointer, return to ENTRY, then process that key as in ENTRY in the same cycle (ENTER_KEY in DONE only clears).
REQ-024 clear SHALL zero digits, count and pointer, go to ENTRY; clear and key_valid together: clear wins, key dropped.
REQ-025 Scan counter SHALL count 0..SCAN_DIV-1; at terminal count scan_sel advances, wrapping NUM_DIGITS-1 -> 0; scanning independent of entry activity.
REQ-026 scan_seg SHALL be the registered hex decode of digit scan_sel, updating one cycle after scan_sel or digit change.

Reset
REQ-027 rst_n low SHALL asynchronously force digits=0, digit_count=0, full=0, entry_done=0, scan_sel=0, scan counter=0, wr_ptr=0, state ENTRY, scan_seg=decode(0)=7'b1111110.
REQ-028 Reset mid-entry or mid-scan SHALL discard all state; first key after release goes to slot 0.

Configuration
REQ-029 With SSD_BLANK_EN defined, scan_seg SHALL be 7'b0000000 for positions not holding a valid digit (mode 0: index >= digit_count; mode 1: index >= digit_count); without it, zeros display as "0".

Structure
REQ-030 Shared package ssd_pkg SHALL hold the entry-state enum, the 7-segment hex lookup constant and blank-pattern constant.
REQ-031 Scan counter and scan_sel SHALL live in sub-module ssd_digit_scanner (params NUM_DIGITS, SCAN_DIV).

Verification
REQ-032 N=4, mode 0: keys 1,2,3,4,5 -> digits=16'h4325 order slot3..0, count 4, full 1.
REQ-033 N=4, mode 1: keys 1,2,3,BKSP -> count 2, digits=16'h0012; then ENTER -> entry_done one pulse, hold.
REQ-034 In DONE, key 7 -> digits=16'h0007, count 1, state ENTRY; ENTER in DONE -> all zero, count 0.
REQ-035 clear and key 9 same cycle -> digits 0, count 0; BKSP at count 0 -> no change.
REQ-036 SCAN_DIV=4, N=3 -> scan_sel 0,1,2,0 advancing every 4 cycles; SSD_BLANK_EN with count 1 -> segs 0 at sel 1,2.
REQ-037 rst_n asserted mid-entry, off clock edge -> outputs at reset values immediately; next key lands in slot 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the keypad entry / seven-segment scanner.
package ssd_pkg;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_DONE  = 1'b1
  } entry_state_e;

  // Active-high segments, bit 6 = a ... bit 0 = g; entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    return SEG_HEX[val];
  endfunction

endpackage

// File: rtl/ssd_digit_scanner.sv
// Free-running digit multiplexer: holds each digit index for SCAN_DIV clocks.
module ssd_digit_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 250_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_sel
);

  localparam int SW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_TC  = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SEL_MAX = SW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          tc;

  assign tc = (cnt_q == CNT_TC);

  always_comb begin
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    sel_d = sel_q;
    if (tc) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign scan_sel = sel_q;

endmodule

// File: rtl/ssd_entry_scanner.sv
// Keypad digit entry buffer with multiplexed seven-segment output.
// Define SSD_BLANK_EN to blank display positions that hold no entered digit.
//
//   state    | meaning
//   ST_ENTRY | accepting digits, backspace and enter
//   ST_DONE  | entry finished, buffer frozen until next key or clear
module ssd_entry_scanner
  import ssd_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter int         SCAN_DIV   = 250_000,
  parameter int         SHIFT_MODE = 0,
  parameter logic [3:0] ENTER_KEY  = 4'hF,
  parameter logic [3:0] BKSP_KEY   = 4'hE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  input  logic                            clear,
  output logic [4*NUM_DIGITS-1:0]         digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            full,
  output logic                            entry_done,
  output logic [$clog2(NUM_DIGITS)-1:0]   scan_sel,
  output logic [6:0]                      scan_seg
);

  localparam int SW   = $clog2(NUM_DIGITS);
  localparam int CNTW = $clog2(NUM_DIGITS + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(NUM_DIGITS);
  localparam logic [SW-1:0]   PTR_MAX = SW'(NUM_DIGITS - 1);

  entry_state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic [SW-1:0]               ptr_q, ptr_d;
  logic                        done_q, done_d;
  logic [6:0]                  seg_q, seg_d;
  logic [SW-1:0]               sel;
  logic                        go;

  ssd_digit_scanner #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_sel (sel)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    go       = 1'b0;

    if (clear) begin
      digits_d = '0;
      count_d  = '0;
      ptr_d    = '0;
      state_d  = ST_ENTRY;
    end else if (key_valid) begin
      go = 1'b1;
      // A key in DONE starts a fresh entry; ENTER there only clears.
      if (state_q == ST_DONE) begin
        digits_d = '0;
        count_d  = '0;
        ptr_d    = '0;
        state_d  = ST_ENTRY;
        go       = (key_code != ENTER_KEY);
      end

      if (go) begin
        if (key_code == ENTER_KEY) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (key_code == BKSP_KEY) begin
          if (count_d != '0) begin
            count_d = count_d - 1'b1;
            if (SHIFT_MODE == 0) begin
              ptr_d           = (ptr_d == '0) ? PTR_MAX : ptr_d - 1'b1;
              digits_d[ptr_d] = 4'h0;
            end else begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                digits_d[i] = digits_d[i+1];
              end
              digits_d[NUM_DIGITS-1] = 4'h0;
            end
          end
        end else begin
          if (SHIFT_MODE == 0) begin
            digits_d[ptr_d] = key_code;
            ptr_d           = (ptr_d == PTR_MAX) ? '0 : ptr_d + 1'b1;
          end else begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
              digits_d[i] = digits_d[i-1];
            end
            digits_d[0] = key_code;
          end
          if (count_d != CNT_MAX) begin
            count_d = count_d + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    seg_d = hex_to_seg(digits_q[sel]);
`ifdef SSD_BLANK_EN
    if (CNTW'(sel) >= count_q) begin
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      digits_q <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      done_q   <= 1'b0;
      seg_q    <= hex_to_seg(4'h0);
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign full        = (count_q == CNT_MAX);
  assign entry_done  = done_q;
  assign scan_sel    = sel;
  assign scan_seg    = seg_q;

endmodule

// File: tb/tb_ssd_entry_scanner.sv
// Bench: three scanner configurations driven with shared directed and random keys, checked against a list-based model.
module tb_ssd_entry_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, key_valid, clear;
  logic [3:0] key_code;

  logic [15:0] dig0, dig1;
  logic [11:0] dig2;
  logic [2:0]  cnt0, cnt1;
  logic [1:0]  cnt2;
  logic        full0, full1, full2, ed0, ed1, ed2;
  logic [1:0]  sel0, sel1, sel2;
  logic [6:0]  seg0, seg1, seg2;

  ssd_entry_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .SHIFT_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .clear(clear),
    .digits(dig0), .digit_count(cnt0), .full(full0), .entry_done(ed0), .scan_sel(sel0), .scan_seg(seg0));
  ssd_entry_scanner #(.NUM_DIGITS(4), .SCAN_DIV(5), .SHIFT_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .clear(clear),
    .digits(dig1), .digit_count(cnt1), .full(full1), .entry_done(ed1), .scan_sel(sel1), .scan_seg(seg1));
  ssd_entry_scanner #(.NUM_DIGITS(3), .SCAN_DIV(4), .SHIFT_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .clear(clear),
    .digits(dig2), .digit_count(cnt2), .full(full2), .entry_done(ed2), .scan_sel(sel2), .scan_seg(seg2));

  localparam int NN[3] = '{4, 4, 3};
  localparam int SD[3] = '{4, 5, 4};

  int total = 0;
  int bad   = 0;

  // Model: instances 0 and 2 are slot buffers, instance 1 is a newest-first list.
  int         slot[3][8];
  int         mcnt[3];
  int         mptr[3];
  bit         mdone[3];
  bit         med[3];
  logic [6:0] mseg[3];
  int         q1[$];
  int         cyc;

  function automatic logic [6:0] hexseg(input int v);
    case (v)
      0: return 7'b1111110;   1: return 7'b0110000;
      2: return 7'b1101101;   3: return 7'b1111001;
      4: return 7'b0110011;   5: return 7'b1011011;
      6: return 7'b1011111;   7: return 7'b1110000;
      8: return 7'b1111111;   9: return 7'b1111011;
      10: return 7'b1110111;  11: return 7'b0011111;
      12: return 7'b1001110;  13: return 7'b0111101;
      14: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic int exp_digit(input int i, input int j);
    if (i == 1) return (j < q1.size()) ? q1[j] : 0;
    return slot[i][j];
  endfunction

  function automatic int exp_count(input int i);
    return (i == 1) ? q1.size() : mcnt[i];
  endfunction

  function automatic logic [63:0] exp_digits(input int i);
    logic [63:0] r = '0;
    for (int j = 0; j < NN[i]; j++) r = r | (64'(exp_digit(i, j)) << (4 * j));
    return r;
  endfunction

  function automatic int exp_sel(input int i);
    return (cyc / SD[i]) % NN[i];
  endfunction

  task automatic clear_inst(input int i);
    for (int j = 0; j < 8; j++) slot[i][j] = 0;
    mcnt[i] = 0;
    mptr[i] = 0;
    if (i == 1) q1.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inst(i);
      mdone[i] = 1'b0;
      med[i]   = 1'b0;
      mseg[i]  = 7'b1111110;
    end
    cyc = 0;
  endtask

  task automatic model_edge(input bit v, input int c, input bit clr);
    bit go;
    int s;
    for (int i = 0; i < 3; i++) begin
      s = exp_sel(i);
      mseg[i] = hexseg(exp_digit(i, s));
`ifdef SSD_BLANK_EN
      if (s >= exp_count(i)) mseg[i] = 7'b0000000;
`endif
    end
    for (int i = 0; i < 3; i++) begin
      med[i] = 1'b0;
      if (clr) begin
        clear_inst(i);
        mdone[i] = 1'b0;
      end else if (v) begin
        go = 1'b1;
        if (mdone[i]) begin
          clear_inst(i);
          mdone[i] = 1'b0;
          if (c == 15) go = 1'b0;
        end
        if (go) begin
          if (c == 15) begin
            med[i]   = 1'b1;
            mdone[i] = 1'b1;
          end else if (c == 14) begin
            if (exp_count(i) > 0) begin
              if (i == 1) void'(q1.pop_front());
              else begin
                mcnt[i] = mcnt[i] - 1;
                mptr[i] = (mptr[i] + NN[i] - 1) % NN[i];
                slot[i][mptr[i]] = 0;
              end
            end
          end else begin
            if (i == 1) begin
              q1.push_front(c);
              if (q1.size() > NN[i]) void'(q1.pop_back());
            end else begin
              slot[i][mptr[i]] = c;
              mptr[i] = (mptr[i] + 1) % NN[i];
              if (mcnt[i] < NN[i]) mcnt[i] = mcnt[i] + 1;
            end
          end
        end
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u0_digits", 64'(dig0), exp_digits(0));
    chk("u0_count",  64'(cnt0), 64'(exp_count(0)));
    chk("u0_full",   64'(full0), 64'(exp_count(0) == NN[0]));
    chk("u0_done",   64'(ed0), 64'(med[0]));
    chk("u0_sel",    64'(sel0), 64'(exp_sel(0)));
    chk("u0_seg",    64'(seg0), 64'(mseg[0]));
    chk("u1_digits", 64'(dig1), exp_digits(1));
    chk("u1_count",  64'(cnt1), 64'(exp_count(1)));
    chk("u1_full",   64'(full1), 64'(exp_count(1) == NN[1]));
    chk("u1_done",   64'(ed1), 64'(med[1]));
    chk("u1_sel",    64'(sel1), 64'(exp_sel(1)));
    chk("u1_seg",    64'(seg1), 64'(mseg[1]));
    chk("u2_digits", 64'(dig2), exp_digits(2));
    chk("u2_count",  64'(cnt2), 64'(exp_count(2)));
    chk("u2_full",   64'(full2), 64'(exp_count(2) == NN[2]));
    chk("u2_done",   64'(ed2), 64'(med[2]));
    chk("u2_sel",    64'(sel2), 64'(exp_sel(2)));
    chk("u2_seg",    64'(seg2), 64'(mseg[2]));
  endtask

  task automatic cycle(input bit v, input int c, input bit clr);
    key_valid = v;
    key_code  = 4'(c);
    clear     = clr;
    @(posedge clk);
    model_edge(v, c, clr);
    @(negedge clk);
    key_valid = 1'b0;
    clear     = 1'b0;
    check_all();
  endtask

  initial begin
    bit v, clr;
    int c;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    for (int k = 1; k <= 5; k++) begin
      cycle(1, k, 0);
      cycle(0, 0, 0);
    end
    chk("slot_wrap_digits", 64'(dig0), 64'h4325);
    chk("slot_wrap_count",  64'(cnt0), 64'd4);
    chk("slot_wrap_full",   64'(full0), 64'd1);

    cycle(0, 0, 1);
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    cycle(1, 3, 0);
    cycle(1, 14, 0);
    chk("shift_bksp_digits", 64'(dig1), 64'h0012);
    chk("shift_bksp_count",  64'(cnt1), 64'd2);
    cycle(1, 15, 0);
    chk("enter_pulse", 64'(ed1), 64'd1);
    cycle(0, 0, 0);
    chk("enter_pulse_end", 64'(ed1), 64'd0);
    chk("enter_hold",      64'(dig1), 64'h0012);

    cycle(1, 7, 0);
    chk("done_key_digits", 64'(dig1), 64'h0007);
    chk("done_key_count",  64'(cnt1), 64'd1);
    cycle(1, 15, 0);
    cycle(1, 15, 0);
    chk("done_enter_digits", 64'(dig1), 64'h0);
    chk("done_enter_count",  64'(cnt1), 64'd0);

    cycle(1, 3, 0);
    cycle(1, 9, 1);
    chk("clear_wins_digits", 64'(dig0), 64'h0);
    chk("clear_wins_count",  64'(cnt0), 64'd0);
    cycle(1, 14, 0);
    chk("bksp_empty", 64'(cnt0), 64'd0);

    cycle(1, 5, 0);
    for (int n = 0; n < 24; n++) cycle(0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 4);
      c   = ($urandom_range(0, 3) == 0) ? 14 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
      clr = ($urandom_range(0, 49) == 0);
      cycle(v, c, clr);
    end

    cycle(0, 0, 1);
    cycle(1, 3, 0);
    cycle(1, 4, 0);
    cycle(0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(1, 6, 0);
    chk("post_reset_slot0", 64'(dig0), 64'h0006);
    for (int n = 0; n < 6; n++) cycle(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
